// File: rtl/spi_rx_deserializer_if.sv
// spi_rx_deserializer_if
//   Register-side bus between the SPI receive deserializer and the Avalon
//   register block.
//   pop       : DATA register read consumed the FIFO head (1-cycle pulse)
//   clear_ov  : write-1-to-clear pulse for the sticky overflow flag
//   rx_data   : FIFO head word, right-aligned, zero when empty
//   rxfe/rxff : FIFO empty / full
//   rxfo      : sticky overflow
//   rx_level  : words held, 0..16
//   master = register block side, slave = deserializer side.
interface spi_rx_deserializer_if;
    logic        pop;
    logic        clear_ov;
    logic [31:0] rx_data;
    logic        rxfe;
    logic        rxff;
    logic        rxfo;
    logic [4:0]  rx_level;

    modport master (
        output pop, clear_ov,
        input  rx_data, rxfe, rxff, rxfo, rx_level
    );

    modport slave (
        input  pop, clear_ov,
        output rx_data, rxfe, rxff, rxfo, rx_level
    );
endinterface

// File: rtl/spi_rx_deserializer.sv
// spi_rx_deserializer
//   Samples spi_rx on the mode-selected edge of spi_clk, assembles words of
//   (word_size+1) bits and pushes them into a show-ahead receive FIFO.
//   Ports:
//     clk, reset   : system clock, synchronous active-high reset
//     enable       : control ENABLE bit
//     word_size    : bits per word minus one (latched when leaving IDLE)
//     mode         : {CPOL,CPHA}; rising edge samples in modes 0/3, falling in 1/2
//     cs_active    : a chip select is asserted (frame in progress)
//     spi_clk      : SPI clock, synchronous to clk
//     spi_rx       : MISO
//     lsb_first    : only with SPI_RX_LSB_FIRST_EN; first bit lands in bit 0
//     bit_cnt_dbg  : current bit index
//     rx_if        : register-side FIFO bus (slave modport)
//   Optional feature macro: SPI_RX_LSB_FIRST_EN.
module spi_rx_deserializer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [4:0] word_size,
    input  logic [1:0] mode,
    input  logic       cs_active,
    input  logic       spi_clk,
    input  logic       spi_rx,
`ifdef SPI_RX_LSB_FIRST_EN
    input  logic       lsb_first,
`endif
    output logic [4:0] bit_cnt_dbg,
    spi_rx_deserializer_if.slave rx_if
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] PUSH  = 2'd2;
    localparam logic [PTR_W:0] FULL_LVL = DEPTH[PTR_W:0];

    logic [1:0]        state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [31:0]       shreg_q, shreg_d;
    logic [4:0]        ws_q, ws_d;
    logic              spi_clk_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    level_q, level_d;
    logic              rxfo_q, rxfo_d;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];

    logic        rise, fall, samp, run, push, do_push, do_pop, ovf;
    logic [31:0] mask;

`ifdef SPI_RX_LSB_FIRST_EN
    logic lsb_q, lsb_d;
`endif

    assign rise = spi_clk & ~spi_clk_q;
    assign fall = ~spi_clk & spi_clk_q;
    // CPOL==CPHA samples on the rising edge, otherwise on the falling edge
    assign samp = (mode[1] == mode[0]) ? rise : fall;
    assign run  = enable & cs_active;
    assign mask = 32'hFFFF_FFFF >> (5'd31 - ws_q);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ws_d      = ws_q;
        push      = 1'b0;
`ifdef SPI_RX_LSB_FIRST_EN
        lsb_d     = lsb_q;
`endif
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                shreg_d   = '0;
                if (run) begin
                    state_d = SHIFT;
                    ws_d    = word_size;
`ifdef SPI_RX_LSB_FIRST_EN
                    lsb_d   = lsb_first;
`endif
                end
            end
            SHIFT: begin
                if (!run) begin
                    // abort: partial word is discarded
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end else if (samp) begin
`ifdef SPI_RX_LSB_FIRST_EN
                    if (lsb_q) shreg_d[bit_cnt_q] = spi_rx;
                    else       shreg_d = {shreg_q[30:0], spi_rx};
`else
                    shreg_d = {shreg_q[30:0], spi_rx};
`endif
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == ws_q) state_d = PUSH;
                end
            end
            PUSH: begin
                push      = 1'b1;
                bit_cnt_d = '0;
                shreg_d   = '0;
                state_d   = run ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO: pop on empty is ignored; a push into a full FIFO is only
    // accepted when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop   = rx_if.pop & (level_q != '0);
        do_push  = push & ((level_q != FULL_LVL) | do_pop);
        ovf      = push & (level_q == FULL_LVL) & ~do_pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = shreg_q & mask;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push & ~do_pop)      level_d = level_q + 1'b1;
        else if (do_pop & ~do_push) level_d = level_q - 1'b1;
        // a fresh overflow wins over a simultaneous clear
        rxfo_d = ovf | (rxfo_q & ~rx_if.clear_ov);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            ws_q      <= '0;
            spi_clk_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rxfo_q    <= 1'b0;
`ifdef SPI_RX_LSB_FIRST_EN
            lsb_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ws_q      <= ws_d;
            spi_clk_q <= spi_clk;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rxfo_q    <= rxfo_d;
`ifdef SPI_RX_LSB_FIRST_EN
            lsb_q     <= lsb_d;
`endif
        end
    end

    // storage needs no reset; reads are gated by the level
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rx_if.rx_data  = (level_q == '0) ? 32'd0 : mem_q[rd_ptr_q];
    assign rx_if.rxfe     = (level_q == '0);
    assign rx_if.rxff     = (level_q == FULL_LVL);
    assign rx_if.rxfo     = rxfo_q;
    assign rx_if.rx_level = level_q;
    assign bit_cnt_dbg    = bit_cnt_q;
endmodule

// File: tb/tb_spi_rx_deserializer.sv
module tb_spi_rx_deserializer;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [4:0] word_size;
    logic [1:0] mode;
    logic       cs_active;
    logic       spi_clk;
    logic       spi_rx;
    logic [4:0] bit_cnt_dbg;
    int         checks = 0;
    int         errors = 0;

    spi_rx_deserializer_if rx_if ();

    spi_rx_deserializer dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .word_size  (word_size),
        .mode       (mode),
        .cs_active  (cs_active),
        .spi_clk    (spi_clk),
        .spi_rx     (spi_rx),
        .bit_cnt_dbg(bit_cnt_dbg),
        .rx_if      (rx_if)
    );

    always #10 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one bit: leave the sampling level, present data, hit the sampling
    // edge, then scramble spi_rx so only the sampled value can matter
    task automatic send_bit(input logic b);
        logic s;
        s = (mode[1] == mode[0]);
        spi_clk = ~s;
        tick(2);
        spi_rx = b;
        tick(2);
        spi_clk = s;
        tick(1);
        spi_rx = ~b;
        tick(1);
    endtask

    task automatic send_word(input logic [31:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(val[i]);
    endtask

    task automatic pop1();
        rx_if.pop = 1'b1;
        tick(1);
        rx_if.pop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; word_size = 5'd7; mode = 2'b00;
        cs_active = 1'b0; spi_clk = 1'b0; spi_rx = 1'b0;
        rx_if.pop = 1'b0; rx_if.clear_ov = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_data", rx_if.rx_data, 32'd0);
        chk("rst_rxfe", {31'd0, rx_if.rxfe}, 32'd1);
        chk("rst_rxff", {31'd0, rx_if.rxff}, 32'd0);
        chk("rst_rxfo", {31'd0, rx_if.rxfo}, 32'd0);
        chk("rst_level", {27'd0, rx_if.rx_level}, 32'd0);
        chk("rst_bitcnt", {27'd0, bit_cnt_dbg}, 32'd0);

        // mode 0, 8 bits, 0xA5, with exact latency on the last bit
        enable = 1'b1; cs_active = 1'b1;
        tick(1);
        send_word(32'h52, 7);
        spi_clk = 1'b0; tick(2);
        spi_rx = 1'b1;  tick(2);
        spi_clk = 1'b1; tick(1);          // edge N samples the 8th bit
        chk("a5_rxfe_N", {31'd0, rx_if.rxfe}, 32'd1);
        tick(1);                          // edge N+1 (PUSH)
        chk("a5_rxfe_N1", {31'd0, rx_if.rxfe}, 32'd0);
        chk("a5_data", rx_if.rx_data, 32'h0000_00A5);
        chk("a5_level", {27'd0, rx_if.rx_level}, 32'd1);
        cs_active = 1'b0;
        pop1();
        chk("a5_pop_rxfe", {31'd0, rx_if.rxfe}, 32'd1);
        chk("a5_pop_data", rx_if.rx_data, 32'd0);

        // mode 1, 16 bits sampled on falling edges
        spi_clk = 1'b0; mode = 2'b01; word_size = 5'd15;
        tick(2);
        cs_active = 1'b1;
        tick(1);
        send_word(32'h1234, 16);
        chk("m1_data", rx_if.rx_data, 32'h0000_1234);
        chk("m1_level", {27'd0, rx_if.rx_level}, 32'd1);
        cs_active = 1'b0;
        pop1();
        pop1();                           // pop on empty is ignored
        chk("empty_pop_data", rx_if.rx_data, 32'd0);
        chk("empty_pop_level", {27'd0, rx_if.rx_level}, 32'd0);

        // abort after 3 bits, then a clean 0x3C
        spi_clk = 1'b0; mode = 2'b00; word_size = 5'd7;
        tick(2);
        cs_active = 1'b1;
        tick(1);
        send_word(32'h5, 3);
        chk("abort_bitcnt", {27'd0, bit_cnt_dbg}, 32'd3);
        cs_active = 1'b0;
        tick(2);
        chk("abort_rxfe", {31'd0, rx_if.rxfe}, 32'd1);
        chk("abort_bitcnt0", {27'd0, bit_cnt_dbg}, 32'd0);
        cs_active = 1'b1;
        tick(1);
        send_word(32'h3C, 8);
        chk("abort_next", rx_if.rx_data, 32'h3C);
        chk("abort_level", {27'd0, rx_if.rx_level}, 32'd1);
        pop1();

        // overflow: 17 words with no pop
        for (int w = 1; w <= 17; w++) send_word(w, 8);
        chk("ov_rxff", {31'd0, rx_if.rxff}, 32'd1);
        chk("ov_level", {27'd0, rx_if.rx_level}, 32'd16);
        chk("ov_rxfo", {31'd0, rx_if.rxfo}, 32'd1);
        chk("ov_head", rx_if.rx_data, 32'h01);
        rx_if.clear_ov = 1'b1;
        tick(1);
        rx_if.clear_ov = 1'b0;
        chk("ov_cleared", {31'd0, rx_if.rxfo}, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            chk("ov_drain", rx_if.rx_data, i);
            pop1();
        end
        chk("ov_drain_rxfe", {31'd0, rx_if.rxfe}, 32'd1);

        // refill to full, then push and pop in the same cycle
        for (int w = 32; w < 48; w++) send_word(w, 8);
        chk("pp_full", {31'd0, rx_if.rxff}, 32'd1);
        send_word(32'h2A, 7);             // first 7 bits of 0x55
        spi_clk = 1'b0; tick(2);
        spi_rx = 1'b1;  tick(2);
        spi_clk = 1'b1; tick(1);          // now in PUSH
        rx_if.pop = 1'b1;
        tick(1);
        rx_if.pop = 1'b0;
        chk("pp_level", {27'd0, rx_if.rx_level}, 32'd16);
        chk("pp_rxfo", {31'd0, rx_if.rxfo}, 32'd0);
        chk("pp_head", rx_if.rx_data, 32'h21);

        // leave 4 words (0x2D,0x2E,0x2F,0x55), reset mid-word
        rx_if.pop = 1'b1;
        tick(12);
        rx_if.pop = 1'b0;
        chk("pre_rst_level", {27'd0, rx_if.rx_level}, 32'd4);
        chk("pre_rst_head", rx_if.rx_data, 32'h2D);
        send_word(32'h3, 3);
        reset = 1'b1;
        tick(1);
        chk("rst2_level", {27'd0, rx_if.rx_level}, 32'd0);
        chk("rst2_rxfe", {31'd0, rx_if.rxfe}, 32'd1);
        chk("rst2_rxfo", {31'd0, rx_if.rxfo}, 32'd0);
        chk("rst2_data", rx_if.rx_data, 32'd0);
        chk("rst2_bitcnt", {27'd0, bit_cnt_dbg}, 32'd0);
        reset = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
